// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, owner encoding and default parameters for dmem_arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;
    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 255;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU/DMA) data memory arbiter with starvation guard and BUSY timeout.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_err_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_done_o,
    output logic              dma_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     to_q, to_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic              busy, grant, grant_dma, timeout, done_cap;
    logic [DATA_W-1:0] cap_data;

    assign busy      = state_q == ST_BUSY;
    assign grant     = state_q == ST_IDLE && (cpu_req_i || dma_req_i);
    assign grant_dma = dma_req_i && (!cpu_req_i || starve_q == SW'(STARVE_LIMIT));
    // An ack in the final BUSY cycle beats the timeout.
    assign timeout   = busy && !mem_ack_i && to_q == TW'(TIMEOUT - 1);
    assign done_cap  = busy && (mem_ack_i || timeout);
    assign cap_data  = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;

    always_comb begin
        state_d     = grant ? ST_BUSY : done_cap ? ST_RESP : state_q == ST_RESP ? ST_IDLE : state_q;
        owner_d     = grant ? grant_dma : owner_q;
        starve_d    = !grant ? starve_q :
                      (grant_dma || !dma_req_i) ? '0 :
                      starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1);
        to_d        = grant ? '0 : (busy && !mem_ack_i) ? to_q + TW'(1) : to_q;
        err_d       = timeout;
        cpu_rdata_d = (done_cap && owner_q == OWN_C) ? cap_data : cpu_rdata_q;
        dma_rdata_d = (done_cap && owner_q == OWN_D) ? cap_data : dma_rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_C;
            starve_q    <= '0;
            to_q        <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            to_q        <= to_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu_done_o  = state_q == ST_RESP && owner_q == OWN_C;
    assign dma_done_o  = state_q == ST_RESP && owner_q == OWN_D;
    assign cpu_err_o   = cpu_done_o && err_q;
    assign dma_err_o   = dma_done_o && err_q;
    assign cpu_stall_o = cpu_req_i && !cpu_done_o;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign mem_req_o   = busy;
    assign mem_we_o    = busy && (owner_q == OWN_D ? dma_we_i : cpu_we_i);
    assign mem_addr_o  = !busy ? '0 : owner_q == OWN_D ? dma_addr_i : cpu_addr_i;
    assign mem_wdata_o = !busy ? '0 : owner_q == OWN_D ? dma_wdata_i : cpu_wdata_i;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_done, cpu_err, cpu_stall, dma_done, dma_err, mem_req, mem_we;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done), .cpu_err_o(cpu_err), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_rdata_o(dma_rdata), .dma_done_o(dma_done), .dma_err_o(dma_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] exp_addr [6];
        rst = 1'b1;
        {cpu_req, cpu_we, dma_req, dma_we, mem_ack} = '0;
        {cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata} = '0;
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dones", {cpu_done, dma_done, cpu_err, dma_err}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        rst = 1'b0;
        tick();

        // CPU read, ack on second BUSY cycle
        cpu_req = 1'b1; cpu_addr = 32'h10;
        #1 check("rd_stall_idle", cpu_stall, 1);
        tick();
        check("rd_busy1_req", mem_req, 1);
        check("rd_busy1_addr", mem_addr, 32'h10);
        check("rd_busy1_we", mem_we, 0);
        check("rd_busy1_stall", cpu_stall, 1);
        tick();
        check("rd_busy2_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        check("rd_done", cpu_done, 1);
        check("rd_err", cpu_err, 0);
        check("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd_stall_done", cpu_stall, 0);
        check("rd_dma_done", dma_done, 0);
        check("rd_resp_mem_req", mem_req, 0);
        cpu_req = 1'b0;
        tick();
        check("rd_done_one_cycle", cpu_done, 0);
        check("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // DMA write, immediate ack
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
        tick();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 32'h40);
        check("wr_mem_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        check("wr_dma_done", dma_done, 1);
        check("wr_cpu_done", cpu_done, 0);
        check("wr_dma_rdata", dma_rdata, 0);
        check("wr_mem_we_resp", mem_we, 0);
        dma_req = 1'b0; dma_we = 1'b0;
        tick();
        check("wr_dma_done_end", dma_done, 0);

        // Spurious ack in IDLE and RESP
        mem_ack = 1'b1; mem_rdata = 32'h00000BAD;
        tick();
        check("sp_idle_req", mem_req, 0);
        check("sp_idle_done", {cpu_done, dma_done}, 0);
        check("sp_idle_rdata", cpu_rdata, 32'hDEADBEEF);
        mem_ack = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h20;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        check("sp_resp_done", cpu_done, 1);
        mem_rdata = 32'h33334444; cpu_req = 1'b0;
        tick();
        check("sp_resp_rdata", cpu_rdata, 32'h11112222);
        check("sp_resp_idle", {mem_req, cpu_done}, 0);
        mem_ack = 1'b0;

        // Timeout without ack
        cpu_req = 1'b1; cpu_addr = 32'h30;
        tick();
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick();
        end
        check("to_busy_cycles", n, 8);
        check("to_done", cpu_done, 1);
        check("to_err", cpu_err, 1);
        check("to_rdata", cpu_rdata, 0);
        check("to_dma_err", dma_err, 0);
        cpu_req = 1'b0;
        tick();
        check("to_err_clear", {cpu_done, cpu_err}, 0);

        // Ack on the last BUSY cycle beats timeout
        dma_req = 1'b1; dma_addr = 32'h50;
        tick();
        repeat (7) tick();
        check("tc_still_busy", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'h00005A5A;
        tick();
        mem_ack = 1'b0;
        check("tc_done", dma_done, 1);
        check("tc_err", dma_err, 0);
        check("tc_rdata", dma_rdata, 32'h00005A5A);
        dma_req = 1'b0;
        tick();

        // Reset during BUSY
        cpu_req = 1'b1; cpu_addr = 32'h60;
        tick();
        check("rb_busy", mem_req, 1);
        rst = 1'b1;
        #1 check("rb_async_req", mem_req, 0);
        tick();
        check("rb_no_done", {cpu_done, dma_done}, 0);
        check("rb_dma_rdata", dma_rdata, 0);
        rst = 1'b0;
        tick();
        check("rb_regrant", mem_req, 1);
        check("rb_regrant_addr", mem_addr, 32'h60);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0;
        check("rb_done", cpu_done, 1);
        check("rb_rdata", cpu_rdata, 32'h77);
        cpu_req = 1'b0;
        tick();

        // Starvation guard: C x4, then D, then C
        exp_addr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h100};
        cpu_req = 1'b1; cpu_addr = 32'h100;
        dma_req = 1'b1; dma_addr = 32'h200;
        mem_ack = 1'b1; mem_rdata = 32'hABCD;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!mem_req && n < 5) begin
                n++;
                tick();
            end
            check($sformatf("sv_grant%0d_req", i), mem_req, 1);
            check($sformatf("sv_grant%0d_addr", i), mem_addr, exp_addr[i]);
            tick();
            check($sformatf("sv_done%0d", i), {cpu_done, dma_done},
                  exp_addr[i] == 32'h200 ? 2'b01 : 2'b10);
        end
        {cpu_req, dma_req, mem_ack} = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
